// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the multiply/divide sequencer: operand width,
// op encodings and sequencer state encodings.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OpMul   = 2'b00,
    OpMulhu = 2'b01,
    OpDivu  = 2'b10,
    OpRemu  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StDone = 2'b11
  } md_state_e;

  function automatic logic op_is_div(logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iteration datapath: 64-bit shift-add product register and 32-bit restoring
// shift-subtract quotient/remainder registers, one step per enabled cycle.
module muldiv_iter
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_mul_step,
  input  logic              i_div_step,
  input  logic [XLEN-1:0]   i_srca,
  input  logic [XLEN-1:0]   i_srcb,
  output logic [2*XLEN-1:0] o_product,
  output logic [XLEN-1:0]   o_quotient,
  output logic [XLEN-1:0]   o_remainder,
  output logic              o_div_zero
);

  logic [XLEN-1:0]   r_srca;
  logic [XLEN-1:0]   r_srcb;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_rem;

  logic [XLEN:0] w_mul_sum;
  logic [XLEN:0] w_rem_shift;
  logic [XLEN:0] w_diff;

  // Multiplier sits in the low half and is consumed LSB-first as the sum shifts in.
  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_srca} : '0);
  assign w_rem_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_srcb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srca <= '0;
      r_srcb <= '0;
      r_prod <= '0;
      r_quot <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_srca <= i_srca;
      r_srcb <= i_srcb;
      r_prod <= {{XLEN{1'b0}}, i_srcb};
      r_quot <= i_srca;
      r_rem  <= '0;
    end else begin
      if (i_mul_step) begin
        r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
      end
      if (i_div_step) begin
        // Quotient register doubles as the dividend shift register.
        if (!w_diff[XLEN]) begin
          r_rem  <= w_diff[XLEN-1:0];
          r_quot <= {r_quot[XLEN-2:0], 1'b1};
        end else begin
          r_rem  <= w_rem_shift[XLEN-1:0];
          r_quot <= {r_quot[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  assign o_product   = r_prod;
  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_div_zero  = (r_srcb == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/MULHU/DIVU/REMU unit: FSM, iteration counter and pipeline
// stall/done/result control around the muldiv_iter datapath.
module muldiv_sequencer #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            startE,
  input  logic [1:0]      opE,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            flushE,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import riscv_pkg::*;

  md_state_e r_state;
  md_state_e w_state_nxt;
  md_op_e    r_op;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  logic [XLEN-1:0] r_result;

  logic w_load;
  logic w_mul_step;
  logic w_div_step;
  logic w_stall;
  logic [2*XLEN-1:0] w_product;
  logic [XLEN-1:0]   w_quotient;
  logic [XLEN-1:0]   w_remainder;
  logic              w_div_zero;
  logic [XLEN-1:0]   w_final;

  muldiv_iter u_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_mul_step  (w_mul_step),
    .i_div_step  (w_div_step),
    .i_srca      (srcaE),
    .i_srcb      (srcbE),
    .o_product   (w_product),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder),
    .o_div_zero  (w_div_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_mul_step  = 1'b0;
    w_div_step  = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (startE && !flushE) begin
          w_load    = 1'b1;
          w_stall   = 1'b1;
          w_cnt_nxt = 5'd31;
          if (op_is_div(opE)) begin
            w_state_nxt = (srcbE == '0) ? StDone : StDiv;
          end else begin
            w_state_nxt = StMul;
          end
        end
      end
      StMul, StDiv: begin
        w_stall = 1'b1;
        if (flushE) begin
          w_state_nxt = StIdle;
        end else begin
          w_mul_step = (r_state == StMul);
          w_div_step = (r_state == StDiv);
          w_cnt_nxt  = r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            w_state_nxt = StDone;
          end
        end
      end
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Divide-by-zero skips iteration, so the quotient register still holds the dividend.
  always_comb begin
    w_final = '0;
    unique case (r_op)
      OpMul:   w_final = w_product[XLEN-1:0];
      OpMulhu: w_final = w_product[2*XLEN-1:XLEN];
      OpDivu:  w_final = w_div_zero ? '1 : w_quotient;
      OpRemu:  w_final = w_div_zero ? w_quotient : w_remainder;
      default: w_final = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_op     <= OpMul;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_op <= md_op_e'(opE);
      end
      if (r_state == StDone) begin
        r_result <= w_final;
      end
    end
  end

  assign stall_req = w_stall;
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StDone);
  assign result    = done ? w_final : r_result;

endmodule
